// File: rtl/motor_pkg.sv
// Shared types and default sizing for the DC motor position controller.
// Pure declarations: no latency, no flow control of its own.
package motor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_PWM_W      = 8;
    localparam int DEF_SLOW_ZONE  = 16;
    localparam int DEF_SETTLE_CYC = 1000;
    localparam int DEF_STALL_CYC  = 1000000;

    // Width of a counter that runs 0 .. max_val-1.
    function automatic int cnt_bits(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/quad_decode.sv
// Quadrature decoder: 3-flop synchroniser per channel feeding a signed up/down counter.
// Count lands on the 3rd clk after an input change; no backpressure, one step per clk max.
module quad_decode
    import motor_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             quadA,
    input  logic             quadB,
    output logic [CNT_W-1:0] position,
    output logic             en
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [2:0]       r_a_sync;
    logic [2:0]       r_b_sync;
    logic [CNT_W-1:0] r_pos;
    logic             w_up;

    // Stage 0 is the metastability catcher; stages 1 and 2 form the edge detector.
    assign en   = r_a_sync[1] ^ r_a_sync[2] ^ r_b_sync[1] ^ r_b_sync[2];
    assign w_up = r_a_sync[1] ^ r_b_sync[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_sync <= '0;
            r_b_sync <= '0;
            r_pos    <= '0;
        end else begin
            r_a_sync <= {r_a_sync[1:0], quadA};
            r_b_sync <= {r_b_sync[1:0], quadB};
            if (en) begin
                r_pos <= w_up ? (r_pos + ONE) : (r_pos - ONE);
            end
        end
    end

    assign position = r_pos;

endmodule

// File: rtl/motor_pos_ctrl.sv
// Closed-loop move-to-target controller driving PWM/dir/brake, two speed zones, settle and stall.
// Bridge outputs lag state by one clk; cmd_ready is high only in IDLE, so commands stall while moving.
module motor_pos_ctrl
    import motor_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int PWM_W      = DEF_PWM_W,
    parameter int SLOW_ZONE  = DEF_SLOW_ZONE,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int STALL_CYC  = DEF_STALL_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             quadA,
    input  logic             quadB,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_target,
    input  logic [PWM_W-1:0] duty_fast,
    input  logic [PWM_W-1:0] duty_slow,
    input  logic             abort,
    output logic             pwm,
    output logic             dir,
    output logic             brake,
    output logic [CNT_W-1:0] position,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int                 SET_W     = cnt_bits(SETTLE_CYC);
    localparam int                 STL_W     = cnt_bits(STALL_CYC);
    localparam logic [SET_W-1:0]   SET_LAST  = SET_W'(SETTLE_CYC - 1);
    localparam logic [STL_W-1:0]   STL_LAST  = STL_W'(STALL_CYC - 1);
    localparam logic [CNT_W:0]     SLOW_LIM  = (CNT_W + 1)'(SLOW_ZONE);
    localparam logic [CNT_W:0]     ONE_EXT   = (CNT_W + 1)'(1);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [CNT_W-1:0] w_pos;
    logic             w_en;
    logic [CNT_W-1:0] r_target;
    logic [PWM_W-1:0] r_pwm_cnt;
    logic [SET_W-1:0] r_settle_cnt;
    logic [STL_W-1:0] r_stall_cnt;
    logic             r_pwm;
    logic             r_dir;
    logic             r_brake;
    logic             r_done;
    logic             r_stall;

    logic [CNT_W-1:0] w_err;
    logic [CNT_W:0]   w_err_ext;
    logic [CNT_W:0]   w_err_abs;
    logic             w_err_zero;
    logic             w_err_pos;
    logic [PWM_W-1:0] w_duty;
    logic             w_accept;
    logic             w_cmd_zero;
    logic             w_settle_exp;
    logic             w_stall_exp;
    logic             w_drive;
    logic             w_pwm_nxt;
    logic             w_dir_nxt;
    logic             w_brake_nxt;
    logic             w_done_nxt;
    logic             w_stall_nxt;

    quad_decode #(
        .CNT_W (CNT_W)
    ) u_quad_decode (
        .clk      (clk),
        .reset    (reset),
        .quadA    (quadA),
        .quadB    (quadB),
        .position (w_pos),
        .en       (w_en)
    );

    // Modular difference read as signed gives the shortest path across the wrap;
    // the extra magnitude bit keeps the most negative error representable.
    assign w_err      = r_target - w_pos;
    assign w_err_zero = (w_err == '0);
    assign w_err_pos  = !w_err[CNT_W-1] && !w_err_zero;
    assign w_err_ext  = {w_err[CNT_W-1], w_err};
    assign w_err_abs  = w_err[CNT_W-1] ? (~w_err_ext + ONE_EXT) : w_err_ext;
    assign w_duty     = (w_err_abs > SLOW_LIM) ? duty_fast : duty_slow;

    assign w_accept     = cmd_valid && cmd_ready && !abort;
    assign w_cmd_zero   = (cmd_target == w_pos);
    assign w_settle_exp = (r_settle_cnt == SET_LAST);
    assign w_stall_exp  = (r_stall_cnt == STL_LAST) && !w_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_cmd_zero ? ST_SETTLE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_err_zero) begin
                    w_state_nxt = ST_SETTLE;
                end else if (w_stall_exp) begin
                    w_state_nxt = ST_FAULT;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_settle_exp) begin
                    w_state_nxt = w_err_zero ? ST_IDLE : ST_RUN;
                end
            end
            ST_FAULT: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Abort is folded into the drive term so the bridge is released on the same edge the FSM leaves RUN.
    always_comb begin
        cmd_ready   = (r_state == ST_IDLE);
        busy        = (r_state == ST_RUN) || (r_state == ST_SETTLE);
        w_drive     = (r_state == ST_RUN) && !abort;
        w_pwm_nxt   = w_drive && (r_pwm_cnt < w_duty);
        w_brake_nxt = !w_drive;
        w_dir_nxt   = w_drive ? w_err_pos : r_dir;
        w_done_nxt  = (r_state == ST_SETTLE) && !abort && w_settle_exp && w_err_zero;
        w_stall_nxt = r_stall;
        if (w_accept) begin
            w_stall_nxt = 1'b0;
        end else if ((r_state == ST_RUN) && !abort && !w_err_zero && w_stall_exp) begin
            w_stall_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt    <= '0;
            r_pwm        <= 1'b0;
            r_dir        <= 1'b0;
            r_brake      <= 1'b1;
            r_done       <= 1'b0;
            r_stall      <= 1'b0;
            r_target     <= '0;
            r_settle_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            r_pwm     <= w_pwm_nxt;
            r_dir     <= w_dir_nxt;
            r_brake   <= w_brake_nxt;
            r_done    <= w_done_nxt;
            r_stall   <= w_stall_nxt;
            if (w_accept) begin
                r_target <= cmd_target;
            end
            // Settle dwell is not restarted by encoder edges; only leaving SETTLE clears it.
            r_settle_cnt <= ((r_state == ST_SETTLE) && !w_settle_exp) ? (r_settle_cnt + SET_W'(1)) : '0;
            r_stall_cnt  <= ((r_state == ST_RUN) && !w_en) ? (r_stall_cnt + STL_W'(1)) : '0;
        end
    end

    assign pwm      = r_pwm;
    assign dir      = r_dir;
    assign brake    = r_brake;
    assign done     = r_done;
    assign stall    = r_stall;
    assign position = w_pos;

endmodule
